// File: rtl/pc_fetch_sequencer.sv
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Fetch-stage PC sequencer with a single outstanding
//               instruction-memory request, a decode hand-off register and
//               flush redirection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_sequencer #(
  parameter int          PC_W     = 12,
  parameter int          INSTR_W  = 32,
  parameter int          PC_INC   = 4,
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               halt_req_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    flush_target_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [PC_W-1:0]    if_pc_o,
  input  logic               if_ready_i,
  input  logic               br_taken_i,
  input  logic [PC_W-1:0]    br_target_i,
  input  logic               jmp_i,
  input  logic [PC_W-1:0]    jmp_target_i,
  output logic [1:0]         pc_sel_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               halted_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] c_pc_inc   = PC_W'(PC_INC);
  localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);

  localparam logic [1:0] c_sel_seq = 2'b00;
  localparam logic [1:0] c_sel_br  = 2'b01;
  localparam logic [1:0] c_sel_jmp = 2'b10;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      fetch_addr_q, fetch_addr_d;
  logic                 kill_q, kill_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      if_pc_q, if_pc_d;

  logic                 acc;
  logic [PC_W-1:0]      next_pc;

  // A flush in ISSUE overrides the handshake: the word is treated as not taken.
  assign acc = (state_q == S_ISSUE) && if_ready_i && !flush_i;

  always_comb begin
    pc_sel_o = c_sel_seq;
    next_pc  = pc_q + c_pc_inc;
    if (acc && jmp_i) begin
      pc_sel_o = c_sel_jmp;
      next_pc  = jmp_target_i;
    end else if (acc && br_taken_i) begin
      pc_sel_o = c_sel_br;
      next_pc  = br_target_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    kill_d       = kill_q;
    instr_d      = instr_q;
    if_pc_d      = if_pc_q;

    if (flush_i) begin
      pc_d = flush_target_i;
    end

    case (state_q)
      S_IDLE, S_HALT: begin
        if (!flush_i && start_i) begin
          state_d      = S_FETCH;
          fetch_addr_d = pc_q;
        end
      end
      S_FETCH: begin
        if (kill_q) begin
          // Drop the stale response and re-issue at the (possibly re-flushed) pc.
          if (imem_ack_i) begin
            kill_d       = 1'b0;
            fetch_addr_d = pc_d;
          end
        end else if (flush_i) begin
          if (imem_ack_i) begin
            fetch_addr_d = flush_target_i;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          if_pc_d = fetch_addr_q;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush_i) begin
          fetch_addr_d = flush_target_i;
          state_d      = S_FETCH;
        end else if (acc) begin
          pc_d         = next_pc;
          fetch_addr_d = next_pc;
          state_d      = halt_req_i ? S_HALT : S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pc_q         <= c_reset_pc;
      fetch_addr_q <= c_reset_pc;
      kill_q       <= 1'b0;
      instr_q      <= '0;
      if_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      kill_q       <= kill_d;
      instr_q      <= instr_d;
      if_pc_q      <= if_pc_d;
    end
  end

  assign imem_req_o  = (state_q == S_FETCH);
  assign imem_addr_o = fetch_addr_q;
  assign if_valid_o  = (state_q == S_ISSUE);
  assign if_instr_o  = instr_q;
  assign if_pc_o     = if_pc_q;
  assign pc_o        = pc_q;
  assign halted_o    = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Directed self-checking bench for pc_fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt_req, flush;
  logic [11:0] flush_target;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [11:0] if_pc;
  logic        if_ready, br_taken, jmp;
  logic [11:0] br_target, jmp_target;
  logic [1:0]  pc_sel;
  logic [11:0] pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  pc_fetch_sequencer #(
    .PC_W(12), .INSTR_W(32), .PC_INC(4), .RESET_PC(12'h000)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .halt_req_i(halt_req),
    .flush_i(flush), .flush_target_i(flush_target),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
    .imem_rdata_i(imem_rdata), .if_valid_o(if_valid), .if_instr_o(if_instr),
    .if_pc_o(if_pc), .if_ready_i(if_ready), .br_taken_i(br_taken),
    .br_target_i(br_target), .jmp_i(jmp), .jmp_target_i(jmp_target),
    .pc_sel_o(pc_sel), .pc_o(pc), .halted_o(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [11:0] a);
    return {8'hA5, 12'h000, a};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, then ack it lat cycles later with word_of(addr).
  task automatic serve(input int lat, output logic [11:0] addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    addr = imem_addr;
    if (ok) begin
      repeat (lat) step();
      imem_ack   = 1'b1;
      imem_rdata = word_of(addr);
      step();
      imem_ack   = 1'b0;
      imem_rdata = '0;
    end
  endtask

  task automatic accept(input bit br, input logic [11:0] bt, input bit j,
                        input logic [11:0] jt, input bit hlt, output logic [1:0] sel);
    if_ready = 1'b1; br_taken = br; br_target = bt; jmp = j; jmp_target = jt;
    halt_req = hlt;
    #1;
    sel = pc_sel;
    step();
    if_ready = 1'b0; br_taken = 1'b0; jmp = 1'b0; halt_req = 1'b0;
  endtask

  // Serve one fetch and check the address and the delivered word.
  task automatic fetch_expect(input string name, input logic [11:0] exp);
    logic [11:0] a;
    bit ok;
    serve(2, a, ok);
    checks++;
    if (!ok || a !== exp) begin
      errors++;
      $display("FAIL %s req: ok=%0b addr=%h required %h", name, ok, a, exp);
    end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== exp || if_instr !== word_of(exp)) begin
      errors++;
      $display("FAIL %s deliver: valid=%b pc=%h instr=%h required 1 %h %h",
               name, if_valid, if_pc, if_instr, exp, word_of(exp));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 12'h000 || pc !== 12'h000 ||
        if_valid !== 1'b0 || halted !== 1'b0 || pc_sel !== 2'b00 ||
        if_instr !== 32'h0 || if_pc !== 12'h000) begin
      errors++;
      $display("FAIL reset: req=%b addr=%h pc=%h valid=%b halted=%b sel=%b required all zero",
               imem_req, imem_addr, pc, if_valid, halted, pc_sel);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sequential();
    logic [1:0] sel;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
      errors++;
      $display("FAIL start_latency: req=%b addr=%h required 1 000", imem_req, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      fetch_expect("seq", 12'(i * 4));
      accept(1'b0, 12'h0, 1'b0, 12'h0, 1'b0, sel);
      checks++;
      if (sel !== 2'b00 || pc !== 12'(i * 4 + 4)) begin
        errors++;
        $display("FAIL seq_accept: sel=%b pc=%h required 00 %h", sel, pc, 12'(i * 4 + 4));
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [1:0] sel;
    fetch_expect("br_src", 12'h010);
    accept(1'b1, 12'h100, 1'b0, 12'h0, 1'b0, sel);
    checks++;
    if (sel !== 2'b01) begin
      errors++;
      $display("FAIL branch_sel: got %b required 01", sel);
    end
    fetch_expect("br_dst", 12'h100);
    accept(1'b1, 12'h100, 1'b1, 12'h200, 1'b0, sel);
    checks++;
    if (sel !== 2'b10) begin
      errors++;
      $display("FAIL jump_beats_branch: got %b required 10", sel);
    end
    fetch_expect("jmp_dst", 12'h200);
    accept(1'b0, 12'h0, 1'b1, 12'hFFC, 1'b0, sel);
    fetch_expect("wrap_src", 12'hFFC);
    accept(1'b0, 12'h0, 1'b0, 12'h0, 1'b0, sel);
    checks++;
    if (pc !== 12'h000) begin
      errors++;
      $display("FAIL wrap_pc: got %h required 000", pc);
    end
    fetch_expect("wrap_dst", 12'h000);
    accept(1'b0, 12'h0, 1'b1, 12'h010, 1'b0, sel);
  endtask

  task automatic test_flush_outstanding();
    bit seen_valid = 1'b0;
    for (int i = 0; i < 20 && !imem_req; i++) step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 12'h010) begin
      errors++;
      $display("FAIL flush_pre: req=%b addr=%h required 1 010", imem_req, imem_addr);
    end
    flush = 1'b1; flush_target = 12'h080;
    step();
    flush = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 12'h010 || pc !== 12'h080) begin
      errors++;
      $display("FAIL kill_hold: req=%b addr=%h pc=%h required 1 010 080",
               imem_req, imem_addr, pc);
    end
    for (int i = 0; i < 2; i++) begin
      seen_valid |= if_valid;
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    seen_valid |= if_valid;
    checks++;
    if (seen_valid || imem_req !== 1'b1 || imem_addr !== 12'h080) begin
      errors++;
      $display("FAIL kill_discard: valid_seen=%b req=%b addr=%h required 0 1 080",
               seen_valid, imem_req, imem_addr);
    end
    fetch_expect("after_flush", 12'h080);
  endtask

  task automatic test_stall_halt();
    logic [1:0] sel;
    int unstable = 0;
    br_taken = 1'b1; br_target = 12'h300;
    #1;
    checks++;
    if (pc_sel !== 2'b00) begin
      errors++;
      $display("FAIL sel_no_acc: got %b required 00", pc_sel);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (if_valid !== 1'b1 || if_pc !== 12'h080 || if_instr !== word_of(12'h080)) unstable++;
    end
    br_taken = 1'b0;
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable cycles required 0", unstable);
    end
    accept(1'b0, 12'h0, 1'b0, 12'h0, 1'b1, sel);
    checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0 || pc !== 12'h084) begin
      errors++;
      $display("FAIL halt: halted=%b req=%b valid=%b pc=%h required 1 0 0 084",
               halted, imem_req, if_valid, pc);
    end
  endtask

  task automatic test_flush_states();
    logic [1:0] sel;
    logic [11:0] a;
    bit ok;
    flush = 1'b1; flush_target = 12'h300;
    step();
    flush = 1'b0;
    checks++;
    if (halted !== 1'b1 || pc !== 12'h300 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_halt: halted=%b pc=%h req=%b required 1 300 0", halted, pc, imem_req);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 12'h300) begin
      errors++;
      $display("FAIL restart: req=%b addr=%h required 1 300", imem_req, imem_addr);
    end
    flush = 1'b1; flush_target = 12'h040; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    flush = 1'b0; imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 12'h040 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_ack: req=%b addr=%h valid=%b required 1 040 0",
               imem_req, imem_addr, if_valid);
    end
    serve(1, a, ok);
    flush = 1'b1; flush_target = 12'h500;
    accept(1'b0, 12'h0, 1'b1, 12'h700, 1'b1, sel);
    flush = 1'b0;
    checks++;
    if (!ok || sel !== 2'b00 || if_valid !== 1'b0 || halted !== 1'b0 ||
        imem_req !== 1'b1 || imem_addr !== 12'h500 || pc !== 12'h500) begin
      errors++;
      $display("FAIL flush_issue: sel=%b valid=%b halted=%b req=%b addr=%h pc=%h required 00 0 0 1 500 500",
               sel, if_valid, halted, imem_req, imem_addr, pc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 12'h000 || imem_addr !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: req=%b pc=%h addr=%h required 0 000 000",
               imem_req, pc, imem_addr);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; halt_req = 1'b0; flush = 1'b0; flush_target = '0;
    imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0; br_taken = 1'b0;
    br_target = '0; jmp = 1'b0; jmp_target = '0;
    step();
    test_reset();
    test_sequential();
    test_branch_jump();
    test_flush_outstanding();
    test_stall_halt();
    test_flush_states();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
